// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud timing helpers
// used by both the RX and TX sides.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

  // Clock cycles per serial bit (integer division).
  function automatic int baud_period(input int clk_hz, input int sclk_hz);
    return clk_hz / sclk_hz;
  endfunction

  // Cycles from the start edge to the middle of the start bit.
  function automatic int baud_half(input int clk_hz, input int sclk_hz);
    return baud_period(clk_hz, sclk_hz) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_stream_if.sv
// Byte-stream side of the UART receiver: ready/valid data plus status pulses.
interface uart_rx_stream_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       frame_err;
  logic       overrun;

  modport master (
    output out_data, out_valid, frame_err, overrun,
    input  out_ready
  );

  modport slave (
    input  out_data, out_valid, frame_err, overrun,
    output out_ready
  );
endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous pin inputs; RST_VAL sets the value
// both stages take in reset (the pin's idle level).
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], d};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= {2{RST_VAL}};
    else          sync_q <= sync_d;
  end

  assign q = sync_q[1];

endmodule

// File: rtl/uart_rx_stream.sv
// 8N1 UART receiver feeding a one-entry ready/valid holding register, with
// single-cycle framing-error and overrun pulses.
module uart_rx_stream
  import uart_pkg::*;
#(
  parameter int CLK_HZ  = 100800000,
  parameter int SCLK_HZ = 115200
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             uart_rxd,
  uart_rx_stream_if.master out_if
);

  localparam int PERIOD = baud_period(CLK_HZ, SCLK_HZ);
  localparam int HALF   = baud_half(CLK_HZ, SCLK_HZ);
  localparam int CNT_W  = $clog2(PERIOD);

  localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(PERIOD - 1);

  logic           rxs;
  uart_rx_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     data_q, data_d;
  logic           valid_q, valid_d;
  logic           frame_err_q, frame_err_d;
  logic           overrun_q, overrun_d;
  logic           byte_done;

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (uart_rxd),
    .q       (rxs)
  );

  always_comb begin
    // NOTE: every _d gets its default first so no branch can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    byte_done   = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_HALF_END) begin
          cnt_d = '0;
          if (rxs) begin
            state_d = IDLE;          // too short to be a start bit
          end else begin
            state_d   = DATA;
            bit_idx_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_BIT_END) begin
          cnt_d     = '0;
          shift_d   = {rxs, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == CNT_BIT_END) begin
          cnt_d = '0;
          if (rxs) begin
            byte_done = 1'b1;
            state_d   = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rxs) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // A drain in the same cycle frees the slot for the incoming byte.
    if (byte_done) begin
      if (!valid_q || out_if.out_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && out_if.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_if.out_data  = data_q;
  assign out_if.out_valid = valid_q;
  assign out_if.frame_err = frame_err_q;
  assign out_if.overrun   = overrun_q;

endmodule
